// File: rtl/trace_pkg.sv
// Shared widths and entry-width helper for the writeback trace buffer.
// Entries carry an extra TRACE_TIME_W timestamp field only when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;
   localparam int TRACE_REG_W  = 5;
   localparam int TRACE_DATA_W = 32;
   localparam int TRACE_TIME_W = 32;
`ifdef TRACE_TIMESTAMP_EN
   localparam int TRACE_TS_STORE_W = TRACE_TIME_W;
`else
   localparam int TRACE_TS_STORE_W = 0;
`endif

   function automatic int trace_entry_w(input int seq_w);
      return seq_w + TRACE_REG_W + TRACE_DATA_W + TRACE_TS_STORE_W;
   endfunction
endpackage

// File: rtl/trace_fifo.sv
// Generic sync FIFO, first-word-fall-through head from flops; push-to-visible latency 1 cycle.
// No backpressure of its own: push into full without a pop is ignored, flush beats push/pop.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [WIDTH-1:0]         head_dat
);
   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;
   localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok, pop_ok;

   // The extra pointer bit distinguishes full from empty when the indices match.
   assign level    = wptr_q - rptr_q;
   assign empty    = (level == '0);
   assign full     = (level == FULL_LVL);
   assign head_dat = mem_q[rptr_q[AW-1:0]];

   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = push_dat;
            wptr_d = wptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         mem_q  <= '{default: '0};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         mem_q  <= mem_d;
      end
   end
endmodule

// File: rtl/writeback_trace_buffer.sv
// Snoops regfile writes into a sequence-tagged trace FIFO; entries visible 1 cycle after capture.
// Never stalls the core: a push into a full FIFO is dropped and counted. Timestamps via TRACE_TIMESTAMP_EN.
module writeback_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int SEQ_W  = 8,
   parameter int DROP_W = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ctrl_writeEnable,
   input  logic [TRACE_REG_W-1:0]  ctrl_writeReg,
   input  logic [TRACE_DATA_W-1:0] data_writeReg,
   input  logic                    trace_ready,
   input  logic                    trace_clear,
   output logic                    trace_valid,
   output logic [SEQ_W-1:0]        trace_seq,
   output logic [TRACE_REG_W-1:0]  trace_reg,
   output logic [TRACE_DATA_W-1:0] trace_data,
   output logic [TRACE_TIME_W-1:0] trace_time,
   output logic [$clog2(DEPTH):0]  trace_level,
   output logic [DROP_W-1:0]       drop_count,
   output logic                    overflow
);
   localparam int ENTRY_W = trace_entry_w(SEQ_W);

   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               ovf_q, ovf_d;
   logic               push_req, drop_now;
   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] push_entry, head_entry;

   assign push_req  = ctrl_writeEnable && (ctrl_writeReg != '0);
   assign trace_valid = !fifo_empty;
   assign fifo_pop  = trace_valid && trace_ready;
   assign fifo_push = push_req && !trace_clear;
   assign drop_now  = push_req && fifo_full && !fifo_pop;

   // Sequence advances on dropped pushes too, so the consumer sees a gap.
   always_comb begin
      seq_d  = seq_q;
      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (trace_clear) begin
         seq_d  = '0;
         drop_d = '0;
         ovf_d  = 1'b0;
      end else begin
         if (push_req) begin
            seq_d = seq_q + SEQ_W'(1);
         end
         if (drop_now) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
               drop_d = drop_q + DROP_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seq_q  <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         seq_q  <= seq_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   assign drop_count = drop_q;
   assign overflow   = ovf_q;

`ifdef TRACE_TIMESTAMP_EN
   logic [TRACE_TIME_W-1:0] time_q, time_d;

   always_comb begin
      time_d = trace_clear ? '0 : time_q + TRACE_TIME_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         time_q <= '0;
      end else begin
         time_q <= time_d;
      end
   end

   assign push_entry = {seq_q, ctrl_writeReg, data_writeReg, time_q};
   assign {trace_seq, trace_reg, trace_data, trace_time} = head_entry;
`else
   assign push_entry = {seq_q, ctrl_writeReg, data_writeReg};
   assign {trace_seq, trace_reg, trace_data} = head_entry;
   assign trace_time = '0;
`endif

   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clock),
      .rst_n    (reset),
      .flush    (trace_clear),
      .push     (fifo_push),
      .push_dat (push_entry),
      .pop      (fifo_pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (trace_level),
      .head_dat (head_entry)
   );
endmodule

// File: tb/tb_writeback_trace_buffer.sv
// Bench for writeback_trace_buffer: vector table, hand-built corner sequences and a random run
// compared against a queue-based reference model.
module tb_writeback_trace_buffer;
   localparam int DEPTH = 16;
`ifdef TRACE_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctrl_writeEnable = 1'b0;
   logic [4:0]  ctrl_writeReg = '0;
   logic [31:0] data_writeReg = '0;
   logic        trace_ready = 1'b0;
   logic        trace_clear = 1'b0;
   logic        trace_valid;
   logic [7:0]  trace_seq;
   logic [4:0]  trace_reg;
   logic [31:0] trace_data;
   logic [31:0] trace_time;
   logic [4:0]  trace_level;
   logic [15:0] drop_count;
   logic        overflow;

   writeback_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(8), .DROP_W(16)) dut (
      .clock(clock), .reset(reset),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .trace_ready(trace_ready), .trace_clear(trace_clear),
      .trace_valid(trace_valid), .trace_seq(trace_seq), .trace_reg(trace_reg),
      .trace_data(trace_data), .trace_time(trace_time), .trace_level(trace_level),
      .drop_count(drop_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the trace as a plain queue of records.
   typedef struct {
      int          seq;
      int          rg;
      logic [31:0] data;
      logic [31:0] tm;
   } ent_t;
   ent_t m_q[$];
   int   m_seq = 0;
   int   m_drops = 0;
   bit   m_ovf = 1'b0;
   int   m_time = 0;

   task automatic model_reset();
      m_q.delete();
      m_seq = 0; m_drops = 0; m_ovf = 1'b0; m_time = 0;
   endtask

   task automatic model_edge();
      bit   do_pop, do_push;
      ent_t e;
      if (trace_clear) begin
         model_reset();
         return;
      end
      do_pop  = (m_q.size() > 0) && trace_ready;
      do_push = ctrl_writeEnable && (ctrl_writeReg != 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
         if (m_q.size() < DEPTH) begin
            e.seq = m_seq; e.rg = int'(ctrl_writeReg); e.data = data_writeReg;
            e.tm = TS_EN ? 32'(m_time) : 32'd0;
            m_q.push_back(e);
         end else begin
            if (m_drops < 65535) m_drops++;
            m_ovf = 1'b1;
         end
         m_seq = (m_seq + 1) % 256;
      end
      m_time++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, trace_valid, m_q.size() > 0);
      chk({tag, ".level"}, trace_level, m_q.size());
      chk({tag, ".drops"}, drop_count, m_drops);
      chk({tag, ".ovf"}, overflow, m_ovf);
      if (m_q.size() > 0) begin
         chk({tag, ".seq"}, trace_seq, m_q[0].seq);
         chk({tag, ".reg"}, trace_reg, m_q[0].rg);
         chk({tag, ".data"}, trace_data, m_q[0].data);
         chk({tag, ".time"}, trace_time, m_q[0].tm);
      end
   endtask

   task automatic step(input logic we, input logic [4:0] rg, input logic [31:0] d,
                       input logic rdy, input logic clr, input string tag);
      ctrl_writeEnable = we; ctrl_writeReg = rg; data_writeReg = d;
      trace_ready = rdy; trace_clear = clr;
      @(posedge clock);
      model_edge();
      #1;
      check_model(tag);
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  rg;
      logic [31:0] d;
      logic        rdy;
      logic        clr;
      logic        ev;
      logic [4:0]  elvl;
      logic [7:0]  eseq;
      logic [4:0]  ereg;
      logic [31:0] edat;
   } vec_t;
   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 5'd1, 8'd0, 5'd5, 32'hDEADBEEF};
      tbl[1] = '{1'b1, 5'd0, 32'h00000001, 1'b0, 1'b0, 1'b1, 5'd1, 8'd0, 5'd5, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 5'd7, 32'h00000011, 1'b1, 1'b0, 1'b1, 5'd1, 8'd1, 5'd7, 32'h00000011};
      tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd1, 8'd1, 5'd7, 32'h00000011};
      tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 5'd0, 32'h0};
      tbl[5] = '{1'b1, 5'd3, 32'h00000033, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 5'd0, 32'h0};
      tbl[6] = '{1'b1, 5'd2, 32'h00000022, 1'b1, 1'b0, 1'b1, 5'd1, 8'd0, 5'd2, 32'h00000022};
      tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 5'd0, 32'h0};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst.valid", trace_valid, 0);
      chk("rst.level", trace_level, 0);
      chk("rst.drops", drop_count, 0);
      chk("rst.ovf", overflow, 0);
      chk("rst.seq", trace_seq, 0);
      chk("rst.data", trace_data, 0);
      chk("rst.time", trace_time, 0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;

      // Timestamps: captures at edges 10 and 13 after reset release
      for (int i = 0; i < 14; i++) begin
         if (i == 10 || i == 13) step(1'b1, 5'(i), 32'hA000 + i, 1'b0, 1'b0, "ts");
         else                    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "ts");
      end
      chk("ts.first", trace_time, TS_EN ? 10 : 0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "ts_pop");
      chk("ts.second", trace_time, TS_EN ? 13 : 0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "ts_pop");
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "clr");

      // Vector table
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].we, tbl[i].rg, tbl[i].d, tbl[i].rdy, tbl[i].clr, "tbl");
         chk($sformatf("tbl%0d.valid", i), trace_valid, tbl[i].ev);
         chk($sformatf("tbl%0d.level", i), trace_level, tbl[i].elvl);
         chk($sformatf("tbl%0d.drops", i), drop_count, 0);
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d.seq", i), trace_seq, tbl[i].eseq);
            chk($sformatf("tbl%0d.reg", i), trace_reg, tbl[i].ereg);
            chk($sformatf("tbl%0d.data", i), trace_data, tbl[i].edat);
         end
      end

      // Overflow: 17 writes with no consumer
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "clr");
      for (int i = 1; i <= 17; i++) step(1'b1, 5'(i), 32'h100 + i, 1'b0, 1'b0, "fill");
      chk("full.level", trace_level, 16);
      chk("full.drops", drop_count, 1);
      chk("full.ovf", overflow, 1);
      chk("full.head", trace_seq, 0);

      // Full with simultaneous push and pop
      step(1'b1, 5'd20, 32'hAA, 1'b1, 1'b0, "fullpp");
      chk("fullpp.level", trace_level, 16);
      chk("fullpp.drops", drop_count, 1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d.seq", i), trace_seq, (i < 15) ? i + 1 : 17);
         step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "drain");
      end
      chk("drain.level", trace_level, 0);

      // Streaming: write every cycle for 300 cycles with the consumer always ready
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "clr");
      for (int i = 0; i < 300; i++)
         step(1'b1, 5'($urandom_range(31, 1)), $urandom, 1'b1, 1'b0, "stream");
      chk("stream.drops", drop_count, 0);
      chk("stream.level", trace_level, 1);
      chk("stream.seq", trace_seq, 43);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 4) != 0, 5'($urandom % 32), $urandom,
              (i < 750) ? (($urandom % 3) == 0) : (($urandom % 3) != 0),
              ($urandom % 64) == 0, "rand");
      end

      // Reset asserted mid-drain
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "clr");
      for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 32'h500 + i, 1'b0, 1'b0, "pre_rst");
      step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "pre_rst");
      step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "pre_rst");
      trace_ready = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      chk("arst.valid", trace_valid, 0);
      chk("arst.level", trace_level, 0);
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "post_rst");
      chk("post_rst.level", trace_level, 0);
      step(1'b1, 5'd9, 32'h99, 1'b0, 1'b0, "post_rst");
      chk("post_rst.seq", trace_seq, 0);
      chk("post_rst.reg", trace_reg, 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
